// File: rtl/adau_cfg_seq.sv
// Replays a table of {reg_addr[15:0], value[7:0]} writes to an ADAU codec through a TWI master.
// Optional: define ADAU_CFG_RETRY_EN to retry a failing entry up to MAX_RETRIES times.
module adau_cfg_seq #(
  parameter int unsigned CLOCKFREQ    = 50,
  parameter int unsigned NUM_ENTRIES  = 64,
  parameter logic [7:0]  DEV_ADDR     = 8'h70,
  parameter int unsigned START_DLY_US = 20000,
  parameter int unsigned GAP_US       = 20,
  parameter int unsigned MAX_RETRIES  = 3
) (
  input  logic        CLK,
  input  logic        SRST_N,
  input  logic        START,
  output logic [7:0]  TBL_ADDR,
  input  logic [23:0] TBL_DATA,
  output logic        MSG_O,
  output logic        STB_O,
  output logic [7:0]  A_O,
  output logic [7:0]  D_O,
  input  logic        DONE_I,
  input  logic        ERR_I,
  output logic        CFG_BUSY,
  output logic        CFG_DONE,
  output logic        CFG_ERR,
  output logic [7:0]  ERR_IDX
);

  localparam logic [31:0] PorCycles = 32'(START_DLY_US * CLOCKFREQ);
  localparam logic [31:0] GapCycles = 32'(GAP_US * CLOCKFREQ);
  localparam logic [31:0] WdCycles  = 32'(20000 * CLOCKFREQ);
  localparam logic [7:0]  LastIdx   = 8'(NUM_ENTRIES - 1);

  if (NUM_ENTRIES < 1 || NUM_ENTRIES > 256 || MAX_RETRIES > 255) begin : gBadParams
    $error("adau_cfg_seq: NUM_ENTRIES or MAX_RETRIES out of range");
  end

  typedef enum logic [2:0] {
    StWaitPor, StFetch, StAddrHi, StAddrLo, StData, StGap, StFinish, StFail
  } stateE;

  stateE       stateQ, stateD;
  logic [31:0] cntQ, cntD;
  logic [7:0]  idxQ, idxD;
  logic [23:0] entryQ, entryD;
  logic [7:0]  errIdxQ, errIdxD;
  logic        byteErr;
`ifdef ADAU_CFG_RETRY_EN
  logic [7:0]  retryQ, retryD;
  logic        redoQ, redoD;
`endif

  always_ff @(posedge CLK) begin
    if (!SRST_N) begin
      stateQ  <= StWaitPor;
      cntQ    <= '0;
      idxQ    <= '0;
      entryQ  <= '0;
      errIdxQ <= '0;
`ifdef ADAU_CFG_RETRY_EN
      retryQ  <= '0;
      redoQ   <= 1'b0;
`endif
    end else begin
      stateQ  <= stateD;
      cntQ    <= cntD;
      idxQ    <= idxD;
      entryQ  <= entryD;
      errIdxQ <= errIdxD;
`ifdef ADAU_CFG_RETRY_EN
      retryQ  <= retryD;
      redoQ   <= redoD;
`endif
    end
  end

  // cntQ is shared: POR wait, fetch latency, per-byte watchdog and inter-message gap.
  always_comb begin
    stateD  = stateQ;
    cntD    = cntQ + 32'd1;
    idxD    = idxQ;
    entryD  = entryQ;
    errIdxD = errIdxQ;
    byteErr = 1'b0;
`ifdef ADAU_CFG_RETRY_EN
    retryD  = retryQ;
    redoD   = redoQ;
`endif
    unique case (stateQ)
      StWaitPor: begin
        if (cntQ + 32'd1 >= PorCycles) begin
          stateD = StFetch;
          cntD   = '0;
        end
      end
      StFetch: begin
        // Table data is valid one cycle after TBL_ADDR moves; capture on the second edge.
        if (cntQ == 32'd1) begin
          stateD = StAddrHi;
          cntD   = '0;
          entryD = TBL_DATA;
        end
      end
      StAddrHi, StAddrLo, StData: begin
        if (DONE_I && !ERR_I) begin
          cntD = '0;
          unique case (stateQ)
            StAddrHi: stateD = StAddrLo;
            StAddrLo: stateD = StData;
            default:  stateD = StGap;
          endcase
        end else if (DONE_I || (cntQ + 32'd1 >= WdCycles)) begin
          byteErr = 1'b1;
        end
      end
      StGap: begin
        if (cntQ + 32'd1 >= GapCycles) begin
          cntD = '0;
`ifdef ADAU_CFG_RETRY_EN
          if (redoQ) begin
            stateD = StFetch;
            redoD  = 1'b0;
          end else
`endif
          if (idxQ == LastIdx) begin
            stateD = StFinish;
          end else begin
            stateD = StFetch;
            idxD   = idxQ + 8'd1;
`ifdef ADAU_CFG_RETRY_EN
            retryD = '0;
`endif
          end
        end
      end
      StFinish, StFail: begin
        cntD = '0;
        if (START) begin
          stateD = StFetch;
          idxD   = '0;
`ifdef ADAU_CFG_RETRY_EN
          retryD = '0;
          redoD  = 1'b0;
`endif
        end
      end
      default: stateD = StWaitPor;
    endcase

    if (byteErr) begin
      cntD = '0;
`ifdef ADAU_CFG_RETRY_EN
      if (retryQ == 8'(MAX_RETRIES)) begin
        stateD  = StFail;
        errIdxD = idxQ;
      end else begin
        stateD = StGap;
        retryD = retryQ + 8'd1;
        redoD  = 1'b1;
      end
`else
      stateD  = StFail;
      errIdxD = idxQ;
`endif
    end
  end

  always_comb begin
    STB_O    = 1'b0;
    MSG_O    = 1'b0;
    A_O      = DEV_ADDR;
    D_O      = '0;
    CFG_BUSY = 1'b1;
    CFG_DONE = 1'b0;
    CFG_ERR  = 1'b0;
    unique case (stateQ)
      StWaitPor: A_O = '0;
      StAddrHi: begin
        STB_O = 1'b1;
        MSG_O = 1'b1;
        D_O   = entryQ[23:16];
      end
      StAddrLo: begin
        STB_O = 1'b1;
        D_O   = entryQ[15:8];
      end
      StData: begin
        STB_O = 1'b1;
        D_O   = entryQ[7:0];
      end
      StFinish: begin
        A_O      = '0;
        CFG_BUSY = 1'b0;
        CFG_DONE = 1'b1;
      end
      StFail: begin
        A_O      = '0;
        CFG_BUSY = 1'b0;
        CFG_ERR  = 1'b1;
      end
      default: ;
    endcase
  end

  assign TBL_ADDR = idxQ;
  assign ERR_IDX  = errIdxQ;

endmodule

// File: tb/tb_adau_cfg_seq.sv
// Scoreboard bench for adau_cfg_seq: TWI responder, table ROM, byte-stream reference model.
module tb_adau_cfg_seq;

  localparam int unsigned NumEntries = 2;
  localparam int unsigned MaxRetries = 2;
  localparam logic [7:0]  DevAddr    = 8'h70;
  localparam int          PorLat     = 10 + 2;  // POR cycles plus two-cycle fetch
  localparam int          StartLat   = 1 + 2;   // START edge plus two-cycle fetch
  localparam int          WdCycles   = 20000;
`ifdef ADAU_CFG_RETRY_EN
  localparam bit RetryEn = 1'b1;
`else
  localparam bit RetryEn = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        SRST_N = 1'b0;
  logic        START = 1'b0;
  logic [7:0]  TBL_ADDR;
  logic [23:0] TBL_DATA = '0;
  logic        MSG_O, STB_O;
  logic [7:0]  A_O, D_O;
  logic        DONE_I = 1'b0;
  logic        ERR_I = 1'b0;
  logic        CFG_BUSY, CFG_DONE, CFG_ERR;
  logic [7:0]  ERR_IDX;

  always #5 CLK = ~CLK;

  adau_cfg_seq #(
    .CLOCKFREQ(1), .NUM_ENTRIES(NumEntries), .DEV_ADDR(DevAddr),
    .START_DLY_US(10), .GAP_US(2), .MAX_RETRIES(MaxRetries)
  ) dut (
    .CLK(CLK), .SRST_N(SRST_N), .START(START), .TBL_ADDR(TBL_ADDR), .TBL_DATA(TBL_DATA),
    .MSG_O(MSG_O), .STB_O(STB_O), .A_O(A_O), .D_O(D_O), .DONE_I(DONE_I), .ERR_I(ERR_I),
    .CFG_BUSY(CFG_BUSY), .CFG_DONE(CFG_DONE), .CFG_ERR(CFG_ERR), .ERR_IDX(ERR_IDX)
  );

  // Synchronous table ROM: one cycle of read latency.
  logic [23:0] tbl [NumEntries];
  always @(posedge CLK)
    TBL_DATA <= (int'(TBL_ADDR) < NumEntries) ? tbl[int'(TBL_ADDR)] : 24'h0;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic       msg;
    logic [7:0] d;
    logic       drop;
  } expByteT;

  expByteT    expQ[$];
  bit [63:0]  errMask = '0, hangMask = '0, pauseMask = '0;
  int         twiG = 0;
  bit         twiPaused = 1'b0, twiNoise = 1'b0;
  bit         expFail = 1'b0;
  int         lastErrIdx = 0;

  // Reference model: walk entries, three bytes each, apply NACK/hang at TWI byte positions.
  task automatic buildRun(input bit [63:0] errs, input bit [63:0] hangs);
    int idx = 0, tries = 0, g = 0;
    bit fail = 1'b0, restart, hit;
    logic [7:0] bytes [3];
    expQ.delete();
    while (idx < NumEntries && !fail) begin
      restart = 1'b0;
      bytes[0] = tbl[idx][23:16];
      bytes[1] = tbl[idx][15:8];
      bytes[2] = tbl[idx][7:0];
      for (int b = 0; b < 3 && !restart && !fail; b++) begin
        hit = errs[g] || hangs[g];
        expQ.push_back('{msg: (b == 0), d: bytes[b], drop: (b == 2) || hit});
        g++;
        if (hit) begin
          if (RetryEn && tries < MaxRetries) begin
            tries++;
            restart = 1'b1;
          end else begin
            fail = 1'b1;
          end
        end
      end
      if (!restart && !fail) begin
        idx++;
        tries = 0;
      end
    end
    expFail = fail;
    if (fail) lastErrIdx = idx;
    errMask  = errs;
    hangMask = hangs;
  endtask

  // TWI responder.
  initial begin : twi
    int lat, cnt;
    forever begin
      @(negedge CLK);
      if (!SRST_N) continue;
      if (STB_O) begin
        if (hangMask[twiG]) begin
          cnt = 0;
          while (STB_O && cnt < WdCycles + 100) begin
            cnt++;
            @(negedge CLK);
          end
          check("watchdog_cycles", cnt, WdCycles);
          twiG++;
        end else if (pauseMask[twiG]) begin
          twiPaused = 1'b1;
          while (STB_O) @(negedge CLK);
          twiPaused = 1'b0;
        end else begin
          lat = $urandom_range(0, 3);
          repeat (lat) @(negedge CLK);
          @(posedge CLK);
          #1 DONE_I = 1'b1;
          ERR_I = errMask[twiG];
          @(posedge CLK);
          #1 DONE_I = 1'b0;
          ERR_I = 1'b0;
          twiG++;
        end
      end else if (twiNoise && $urandom_range(0, 2) == 0) begin
        @(posedge CLK);
        #1 DONE_I = 1'b1;
        ERR_I = 1'($urandom_range(0, 1));
        @(posedge CLK);
        #1 DONE_I = 1'b0;
        ERR_I = 1'b0;
      end
    end
  end

  // Monitor: pop on each new byte presentation, check strobe behaviour after each ack.
  initial begin : mon
    bit prevStb = 1'b0, prevAck = 1'b0, lastDrop = 1'b0;
    expByteT e;
    forever begin
      @(negedge CLK);
      if (!SRST_N) begin
        prevStb = 1'b0;
        prevAck = 1'b0;
        continue;
      end
      if (prevAck) check("stb_after_ack", STB_O, !lastDrop);
      if (STB_O && (!prevStb || prevAck)) begin
        if (expQ.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_byte: got d=%0h msg=%0b expected none", D_O, MSG_O);
        end else begin
          e = expQ.pop_front();
          check("msg", MSG_O, e.msg);
          check("data", D_O, e.d);
          check("dev_addr", A_O, DevAddr);
          lastDrop = e.drop;
        end
      end
      prevAck = DONE_I && STB_O;
      prevStb = STB_O;
    end
  end

  task automatic randTable();
    for (int i = 0; i < NumEntries; i++) tbl[i] = 24'($urandom());
  endtask

  task automatic startRun(input bit [63:0] errs, input bit [63:0] hangs, input bit glitch);
    int held = lastErrIdx;
    int lat;
    twiG = 0;
    buildRun(errs, hangs);
    @(negedge CLK);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    lat = 1;
    check("start_clears_done", CFG_DONE, 0);
    check("start_clears_err", CFG_ERR, 0);
    check("erridx_held", ERR_IDX, held);
    while (!STB_O && lat < 50) begin
      @(negedge CLK);
      lat++;
    end
    check("start_latency", lat, StartLat);
    if (glitch) begin
      repeat ($urandom_range(1, 6)) @(negedge CLK);
      START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
    end
  endtask

  task automatic waitEnd(input string name);
    int cyc = 0;
    while (CFG_BUSY && cyc < 25000) begin
      @(negedge CLK);
      cyc++;
    end
    check({name, "_busy"}, CFG_BUSY, 0);
    check({name, "_done"}, CFG_DONE, !expFail);
    check({name, "_err"}, CFG_ERR, expFail);
    check({name, "_erridx"}, ERR_IDX, lastErrIdx);
    check({name, "_drained"}, expQ.size(), 0);
  endtask

  task automatic porRelease(input string name);
    int lat = 0;
    SRST_N = 1'b1;
    while (!STB_O && lat < 200) begin
      @(negedge CLK);
      lat++;
    end
    check(name, lat, PorLat);
  endtask

  initial begin : stim
    bit [63:0] errs;
    int n;
    tbl[0] = 24'h400001;
    tbl[1] = 24'h4015AA;
    repeat (3) @(negedge CLK);
    check("rst_stb", STB_O, 0);
    check("rst_msg", MSG_O, 0);
    check("rst_a", A_O, 0);
    check("rst_d", D_O, 0);
    check("rst_tbl_addr", TBL_ADDR, 0);
    check("rst_busy", CFG_BUSY, 1);
    check("rst_done", CFG_DONE, 0);
    check("rst_err", CFG_ERR, 0);
    check("rst_erridx", ERR_IDX, 0);

    buildRun('0, '0);
    porRelease("por_latency");
    waitEnd("run_spec");

    twiNoise = 1'b1;
    repeat (20) @(negedge CLK);
    twiNoise = 1'b0;
    repeat (3) @(negedge CLK);
    check("noise_done_hold", CFG_DONE, 1);
    check("noise_busy_hold", CFG_BUSY, 0);

    randTable();
    startRun('0, '0, 1'b1);
    waitEnd("run_rand0");

    randTable();
    startRun(64'h10, '0, 1'b0);  // NACK on entry 1 low address byte
    waitEnd("run_nack_e1_lo");

    for (int r = 0; r < 6; r++) begin
      randTable();
      errs = '0;
      if ($urandom_range(0, 1) == 1) errs[$urandom_range(0, 7)] = 1'b1;
      startRun(errs, '0, errs == '0);
      waitEnd("run_random");
    end

`ifdef ADAU_CFG_RETRY_EN
    randTable();
    startRun(64'h3, '0, 1'b0);
    waitEnd("run_retry_ok");
    startRun(64'h7, '0, 1'b0);
    waitEnd("run_retry_fail");
`endif

    randTable();
    startRun('0, 64'h4, 1'b0);  // no response to entry 0 data byte
    waitEnd("run_watchdog");

    pauseMask = 64'h4;
    startRun('0, '0, 1'b0);
    n = 0;
    while (!twiPaused && n < 100) begin
      @(negedge CLK);
      n++;
    end
    check("pause_reached", twiPaused, 1);
    SRST_N = 1'b0;
    @(negedge CLK);
    check("midrst_stb", STB_O, 0);
    check("midrst_busy", CFG_BUSY, 1);
    check("midrst_done", CFG_DONE, 0);
    @(negedge CLK);
    pauseMask = '0;
    twiG = 0;
    lastErrIdx = 0;
    buildRun('0, '0);
    porRelease("por_after_reset");
    waitEnd("run_after_reset");

    randTable();
    startRun('0, '0, 1'b0);
    waitEnd("run_final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : timeout
    #2000000;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "timeout");
  end

endmodule
